regfile_write_arbiter: RTL

Write-port controller for the 32×32 integer register file of the single-cycle core. It owns the file's single write port (write enable, destination index, write data) and shares it between the core's writeback path and a debug/loader write port using valid/ready. After reset it runs an initialization sequence that writes every register x1..x31, including the stack-pointer seed. The block sits between core writeback, the debug bridge and the register file.

---
 rtl/regfile_write_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 32x32 register file: core writeback vs debug writes with starvation forcing.
// Define REGFILE_INIT_SEQ_EN to enable the post-reset x1..x31 initialization sequence.
module regfile_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned SP_REG       = 2,
  parameter logic [31:0] SP_INIT      = 32'd64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_we,
  input  logic [4:0]  core_rd,
  input  logic [31:0] core_wdata,
  output logic        core_stall,
  input  logic        dbg_valid,
  input  logic [4:0]  dbg_rd,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ready,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic        init_done
);

`ifdef REGFILE_INIT_SEQ_EN
  typedef enum logic [1:0] {INIT, RUN, FORCE} state_t;
  localparam state_t RESET_STATE = INIT;
  localparam logic [4:0] SP_IDX = 5'(SP_REG);
`else
  typedef enum logic [1:0] {RUN, FORCE} state_t;
  localparam state_t RESET_STATE = RUN;
`endif

  localparam logic [7:0] STARVE_LAST = 8'(STARVE_LIMIT - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RESET_STATE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

`ifdef REGFILE_INIT_SEQ_EN
  logic [4:0] idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= 5'd1;
    end else if (state == INIT) begin
      idx <= idx + 5'd1;
    end
  end

  assign init_done = rst_n && (state != INIT);
`else
  logic unused_cfg;
  assign unused_cfg = ^{SP_INIT, 5'(SP_REG)};
  assign init_done  = 1'b1;
`endif

  always_comb begin
    state_nxt  = state;
    wait_nxt   = wait_cnt;
    rf_we      = 1'b0;
    rf_rd      = '0;
    rf_wdata   = '0;
    core_stall = 1'b1;
    dbg_ready  = 1'b0;
    // Outputs are gated by rst_n so the port is quiet for the whole reset pulse.
    if (rst_n) begin
      case (state)
`ifdef REGFILE_INIT_SEQ_EN
        INIT: begin
          rf_we     = 1'b1;
          rf_rd     = idx;
          rf_wdata  = (idx == SP_IDX) ? SP_INIT : '0;
          state_nxt = (idx == 5'd31) ? RUN : INIT;
        end
`endif
        RUN: begin
          core_stall = 1'b0;
          if (core_we) begin
            rf_we    = (core_rd != '0);
            rf_rd    = core_rd;
            rf_wdata = core_wdata;
            if (dbg_valid) begin
              if (wait_cnt == STARVE_LAST) state_nxt = FORCE;
              if (wait_cnt != '1) wait_nxt = wait_cnt + 8'd1;
            end else begin
              wait_nxt = '0;
            end
          end else if (dbg_valid) begin
            dbg_ready = 1'b1;
            rf_we     = (dbg_rd != '0);
            rf_rd     = dbg_rd;
            rf_wdata  = dbg_wdata;
            wait_nxt  = '0;
          end else begin
            wait_nxt = '0;
          end
        end
        FORCE: begin
          state_nxt = RUN;
          wait_nxt  = '0;
          if (dbg_valid) begin
            dbg_ready = 1'b1;
            rf_we     = (dbg_rd != '0);
            rf_rd     = dbg_rd;
            rf_wdata  = dbg_wdata;
          end
        end
        default: state_nxt = RESET_STATE;
      endcase
    end
  end

endmodule
